// File: rtl/color_uart_tx.sv
// rtl/color_uart_tx.sv - sends "<letter>\r\n" over 8N1 UART whenever a new non-zero colour code appears
module color_uart_tx #(
  parameter int CLKS_PER_BIT = 104
) (
  input  logic       clk_1MHz,
  input  logic       rst_n,
  input  logic [1:0] color,
  output logic       tx,
  output logic       busy,
  output logic       msg_done
);

  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] CYC_LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] CYC_ONE  = CW'(1);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t          state_q, state_d;
  logic            tx_q, tx_d;
  logic            busy_q, busy_d;
  logic            msg_done_q, msg_done_d;
  logic [1:0]      last_color_q, last_color_d;
  logic [1:0]      msg_color_q, msg_color_d;
  logic [1:0]      byte_idx_q, byte_idx_d;
  logic [2:0]      bit_idx_q, bit_idx_d;
  logic [CW-1:0]   cyc_q, cyc_d;

  logic [7:0]      cur_byte;
  logic            bit_end;

  assign bit_end = (cyc_q == CYC_LAST);

  // Byte content comes only from the snapshot so mid-message colour changes cannot corrupt it.
  always_comb begin
    cur_byte = 8'h0A;
    case (byte_idx_q)
      2'd0: begin
        case (msg_color_q)
          2'd1:    cur_byte = 8'h52;
          2'd2:    cur_byte = 8'h47;
          2'd3:    cur_byte = 8'h42;
          default: cur_byte = 8'h00;
        endcase
      end
      2'd1:    cur_byte = 8'h0D;
      default: cur_byte = 8'h0A;
    endcase
  end

  always_comb begin
    state_d      = state_q;
    tx_d         = tx_q;
    busy_d       = busy_q;
    msg_done_d   = 1'b0;
    last_color_d = last_color_q;
    msg_color_d  = msg_color_q;
    byte_idx_d   = byte_idx_q;
    bit_idx_d    = bit_idx_q;
    cyc_d        = bit_end ? '0 : cyc_q + CYC_ONE;

    case (state_q)
      IDLE: begin
        tx_d   = 1'b1;
        busy_d = 1'b0;
        cyc_d  = '0;
        if (color != 2'd0 && color != last_color_q) begin
          msg_color_d  = color;
          last_color_d = color;
          byte_idx_d   = 2'd0;
          state_d      = START;
          tx_d         = 1'b0;
          busy_d       = 1'b1;
        end
      end
      START: begin
        if (bit_end) begin
          state_d   = DATA;
          bit_idx_d = 3'd0;
          tx_d      = cur_byte[0];
        end
      end
      DATA: begin
        if (bit_end) begin
          if (bit_idx_q == 3'd7) begin
            state_d = STOP;
            tx_d    = 1'b1;
          end else begin
            bit_idx_d = bit_idx_q + 3'd1;
            tx_d      = cur_byte[bit_idx_q + 3'd1];
          end
        end
      end
      STOP: begin
        if (bit_end) begin
          if (byte_idx_q != 2'd2) begin
            byte_idx_d = byte_idx_q + 2'd1;
            state_d    = START;
            tx_d       = 1'b0;
          end else begin
            state_d    = IDLE;
            busy_d     = 1'b0;
            msg_done_d = 1'b1;
          end
        end
      end
      default: begin
        state_d = IDLE;
        tx_d    = 1'b1;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk_1MHz) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      tx_q         <= 1'b1;
      busy_q       <= 1'b0;
      msg_done_q   <= 1'b0;
      last_color_q <= 2'd0;
      msg_color_q  <= 2'd0;
      byte_idx_q   <= 2'd0;
      bit_idx_q    <= 3'd0;
      cyc_q        <= '0;
    end else begin
      state_q      <= state_d;
      tx_q         <= tx_d;
      busy_q       <= busy_d;
      msg_done_q   <= msg_done_d;
      last_color_q <= last_color_d;
      msg_color_q  <= msg_color_d;
      byte_idx_q   <= byte_idx_d;
      bit_idx_q    <= bit_idx_d;
      cyc_q        <= cyc_d;
    end
  end

  assign tx       = tx_q;
  assign busy     = busy_q;
  assign msg_done = msg_done_q;

endmodule

// File: tb/tb_color_uart_tx.sv
// tb/tb_color_uart_tx.sv - directed self-checking bench for color_uart_tx (fast and default baud instances)
module tb_color_uart_tx;

  logic       clk;
  logic       rst_n;
  logic [1:0] color4;
  logic [1:0] color104;
  logic       tx4, busy4, done4;
  logic       tx104, busy104, done104;
  logic       big_sel;

  int tests_run;
  int tests_failed;
  int busy_cnt;
  int done_cnt;

  wire rx_line  = big_sel ? tx104   : tx4;
  wire mon_busy = big_sel ? busy104 : busy4;
  wire mon_done = big_sel ? done104 : done4;

  color_uart_tx #(.CLKS_PER_BIT(4)) dut4 (
    .clk_1MHz (clk),
    .rst_n    (rst_n),
    .color    (color4),
    .tx       (tx4),
    .busy     (busy4),
    .msg_done (done4)
  );

  color_uart_tx dut104 (
    .clk_1MHz (clk),
    .rst_n    (rst_n),
    .color    (color104),
    .tx       (tx104),
    .busy     (busy104),
    .msg_done (done104)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Mid-bit receiver; also flags any bit whose level is not constant for its full width.
  task automatic recv_byte(input int n, input int bound, output logic [7:0] b,
                           output int wait_cyc, output bit stable);
    logic [9:0] mid;
    logic       first;
    wait_cyc = 0;
    stable   = 1'b1;
    b        = 8'hxx;
    mid      = '0;
    first    = 1'b0;
    while (rx_line !== 1'b0 && wait_cyc < bound) begin
      @(negedge clk);
      wait_cyc++;
    end
    if (rx_line !== 1'b0) begin
      stable = 1'b0;
      return;
    end
    for (int k = 0; k < 10; k++) begin
      for (int c = 0; c < n; c++) begin
        if (c == 0) first = rx_line;
        else if (rx_line !== first) stable = 1'b0;
        if (c == n / 2) mid[k] = rx_line;
        if (mon_busy === 1'b1) busy_cnt++;
        if (mon_done === 1'b1) done_cnt++;
        @(negedge clk);
      end
    end
    if (mid[0] !== 1'b0 || mid[9] !== 1'b1) stable = 1'b0;
    b = mid[8:1];
  endtask

  task automatic recv_msg(input int n, output logic [7:0] b0, output logic [7:0] b1,
                          output logic [7:0] b2, output int w0, output int gap, output bit st);
    int w1, w2;
    bit s0, s1, s2;
    busy_cnt = 0;
    done_cnt = 0;
    recv_byte(n, 20, b0, w0, s0);
    recv_byte(n, 4, b1, w1, s1);
    recv_byte(n, 4, b2, w2, s2);
    gap = w1 + w2;
    st  = s0 & s1 & s2;
  endtask

  task automatic test_reset;
    rst_n    = 1'b0;
    color4   = 2'd2;
    color104 = 2'd2;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      tests_run++;
      if (tx4 !== 1'b1 || busy4 !== 1'b0 || done4 !== 1'b0) begin
        tests_failed++;
        $display("FAIL reset4 cyc%0d: tx/busy/done=%b%b%b expected 100", i, tx4, busy4, done4);
      end
      tests_run++;
      if (tx104 !== 1'b1 || busy104 !== 1'b0 || done104 !== 1'b0) begin
        tests_failed++;
        $display("FAIL reset104 cyc%0d: tx/busy/done=%b%b%b expected 100", i, tx104, busy104, done104);
      end
    end
    color4   = 2'd0;
    color104 = 2'd0;
    rst_n    = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_message;
    logic [7:0] b0, b1, b2;
    int w0, gap;
    bit st;
    big_sel = 1'b0;
    color4  = 2'd1;
    recv_msg(4, b0, b1, b2, w0, gap, st);
    tests_run++;
    if (b0 !== 8'h52) begin tests_failed++; $display("FAIL msg_letter: got %h expected 52", b0); end
    tests_run++;
    if (b1 !== 8'h0D) begin tests_failed++; $display("FAIL msg_cr: got %h expected 0d", b1); end
    tests_run++;
    if (b2 !== 8'h0A) begin tests_failed++; $display("FAIL msg_lf: got %h expected 0a", b2); end
    tests_run++;
    if (w0 !== 1) begin tests_failed++; $display("FAIL msg_latency: got %0d expected 1", w0); end
    tests_run++;
    if (gap !== 0) begin tests_failed++; $display("FAIL msg_gap: got %0d expected 0", gap); end
    tests_run++;
    if (st !== 1'b1) begin tests_failed++; $display("FAIL msg_framing: got %b expected 1", st); end
    tests_run++;
    if (busy_cnt !== 120) begin tests_failed++; $display("FAIL msg_busy_len: got %0d expected 120", busy_cnt); end
    tests_run++;
    if (done_cnt !== 0) begin tests_failed++; $display("FAIL msg_done_early: got %0d expected 0", done_cnt); end
    tests_run++;
    if (busy4 !== 1'b0 || done4 !== 1'b1) begin
      tests_failed++;
      $display("FAIL msg_end: busy/done=%b%b expected 01", busy4, done4);
    end
    @(negedge clk);
    tests_run++;
    if (done4 !== 1'b0) begin tests_failed++; $display("FAIL msg_done_pulse: got %b expected 0", done4); end
  endtask

  task automatic test_no_repeat;
    int bad;
    logic [1:0] seq_col [3];
    int         seq_len [3];
    seq_col[0] = 2'd1; seq_len[0] = 500;
    seq_col[1] = 2'd0; seq_len[1] = 50;
    seq_col[2] = 2'd1; seq_len[2] = 150;
    for (int p = 0; p < 3; p++) begin
      bad    = 0;
      color4 = seq_col[p];
      repeat (seq_len[p]) begin
        @(negedge clk);
        if (tx4 !== 1'b1 || busy4 !== 1'b0 || done4 !== 1'b0) bad++;
      end
      tests_run++;
      if (bad !== 0) begin tests_failed++; $display("FAIL no_repeat phase%0d: %0d active cycles expected 0", p, bad); end
    end
  endtask

  task automatic test_change_during;
    logic [7:0] b0, b1, b2;
    int w0, gap, bad;
    bit st;
    rst_n  = 1'b0;
    color4 = 2'd0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    color4 = 2'd1;
    fork
      begin
        repeat (20) @(negedge clk);
        color4 = 2'd2;
        repeat (40) @(negedge clk);
        color4 = 2'd3;
      end
    join_none
    recv_msg(4, b0, b1, b2, w0, gap, st);
    tests_run++;
    if ({b0, b1, b2} !== 24'h520D0A || st !== 1'b1 || busy_cnt !== 120) begin
      tests_failed++;
      $display("FAIL change_first: got %h%h%h st=%b busy=%0d expected 520d0a st=1 busy=120", b0, b1, b2, st, busy_cnt);
    end
    recv_msg(4, b0, b1, b2, w0, gap, st);
    tests_run++;
    if (w0 !== 1) begin tests_failed++; $display("FAIL change_idle_gap: got %0d expected 1", w0); end
    tests_run++;
    if (b0 !== 8'h42) begin tests_failed++; $display("FAIL change_second_letter: got %h expected 42", b0); end
    tests_run++;
    if ({b1, b2} !== 16'h0D0A || st !== 1'b1) begin
      tests_failed++;
      $display("FAIL change_second_tail: got %h%h st=%b expected 0d0a st=1", b1, b2, st);
    end
    bad = 0;
    repeat (200) begin
      @(negedge clk);
      if (busy4 !== 1'b0 || tx4 !== 1'b1) bad++;
    end
    tests_run++;
    if (bad !== 0) begin tests_failed++; $display("FAIL change_no_third: %0d active cycles expected 0", bad); end
  endtask

  task automatic test_reset_mid;
    logic [7:0] b0, b1, b2;
    int w0, gap;
    bit st;
    rst_n  = 1'b0;
    color4 = 2'd0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    color4 = 2'd3;
    repeat (18) @(negedge clk);
    tests_run++;
    if (busy4 !== 1'b1 || tx4 !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_mid_bit3: busy/tx=%b%b expected 10", busy4, tx4);
    end
    rst_n = 1'b0;
    @(negedge clk);
    tests_run++;
    if (tx4 !== 1'b1 || busy4 !== 1'b0 || done4 !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_mid_abort: tx/busy/done=%b%b%b expected 100", tx4, busy4, done4);
    end
    rst_n = 1'b1;
    recv_msg(4, b0, b1, b2, w0, gap, st);
    tests_run++;
    if ({b0, b1, b2} !== 24'h420D0A || w0 !== 1 || st !== 1'b1 || busy_cnt !== 120) begin
      tests_failed++;
      $display("FAIL reset_mid_resend: got %h%h%h w=%0d st=%b busy=%0d expected 420d0a w=1 st=1 busy=120",
               b0, b1, b2, w0, st, busy_cnt);
    end
  endtask

  task automatic test_default_baud;
    logic [7:0] b0, b1, b2;
    int w0, gap;
    bit st;
    big_sel  = 1'b1;
    color104 = 2'd2;
    recv_msg(104, b0, b1, b2, w0, gap, st);
    tests_run++;
    if (b0 !== 8'h47) begin tests_failed++; $display("FAIL baud_letter: got %h expected 47", b0); end
    tests_run++;
    if ({b1, b2} !== 16'h0D0A) begin tests_failed++; $display("FAIL baud_tail: got %h%h expected 0d0a", b1, b2); end
    tests_run++;
    if (st !== 1'b1 || w0 !== 1 || gap !== 0) begin
      tests_failed++;
      $display("FAIL baud_framing: st=%b w=%0d gap=%0d expected st=1 w=1 gap=0", st, w0, gap);
    end
    tests_run++;
    if (busy_cnt !== 3120) begin tests_failed++; $display("FAIL baud_busy_len: got %0d expected 3120", busy_cnt); end
    tests_run++;
    if (busy104 !== 1'b0 || done104 !== 1'b1) begin
      tests_failed++;
      $display("FAIL baud_end: busy/done=%b%b expected 01", busy104, done104);
    end
    big_sel = 1'b0;
  endtask

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    busy_cnt     = 0;
    done_cnt     = 0;
    big_sel      = 1'b0;
    rst_n        = 1'b0;
    color4       = 2'd0;
    color104     = 2'd0;
    test_reset();
    test_message();
    test_no_repeat();
    test_change_during();
    test_reset_mid();
    test_default_baud();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
